// File: rtl/dm_ctrl_if.sv
// Pipeline-side data-memory access and peripheral req/ack bus for dm_ctrl.
interface dm_ctrl_if;
  // Pipeline EX_DM slot
  logic        dm_re_EX_DM;
  logic        dm_we_EX_DM;
  logic [31:0] addr_EX_DM;
  logic [31:0] wrt_data_EX_DM;
  logic [31:0] dm_rd_data_EX_DM;
  logic        stall_DM;

  // Peripheral bus
  logic        io_req;
  logic        io_we;
  logic [15:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_ack;
  logic        bus_err;

  // Controller side: consumes pipeline requests and peripheral responses
  modport slave (
    input  dm_re_EX_DM,
    input  dm_we_EX_DM,
    input  addr_EX_DM,
    input  wrt_data_EX_DM,
    output dm_rd_data_EX_DM,
    output stall_DM,
    output io_req,
    output io_we,
    output io_addr,
    output io_wdata,
    input  io_rdata,
    input  io_ack,
    output bus_err
  );

  // Environment side: pipeline plus peripheral
  modport master (
    output dm_re_EX_DM,
    output dm_we_EX_DM,
    output addr_EX_DM,
    output wrt_data_EX_DM,
    input  dm_rd_data_EX_DM,
    input  stall_DM,
    input  io_req,
    input  io_we,
    input  io_addr,
    input  io_wdata,
    output io_rdata,
    output io_ack,
    input  bus_err
  );
endinterface

// File: rtl/dm_ctrl.sv
// Data-memory stage controller: zero-latency local RAM plus stalling
// memory-mapped I/O window with req/ack handshake and timeout.
module dm_ctrl #(
  parameter int unsigned DM_AW      = 12,
  parameter logic [15:0] IO_BASE_HI = 16'hC000,
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  dm_ctrl_if.slave    bus
);

  localparam int unsigned DEPTH = 1 << DM_AW;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic               io_req_q;
  logic               io_we_q;
  logic [15:0]        io_addr_q;
  logic [31:0]        io_wdata_q;
  logic [31:0]        rdata_q;
  logic [TMO_W-1:0]   tmo_cnt_q;
  logic               bus_err_q;

  logic [31:0]        mem [DEPTH];
  logic [31:0]        ram_rdata_q;

  logic               acc_c;
  logic               io_sel_c;
  logic               is_load_c;
  logic [DM_AW-1:0]   ram_idx_c;
  logic               stall_c;
  logic               ram_we_c;
  logic [31:0]        rd_data_c;

  // Address decode; a simultaneous read+write is treated as a store
  always_comb begin
    acc_c     = bus.dm_re_EX_DM | bus.dm_we_EX_DM;
    io_sel_c  = (bus.addr_EX_DM[31:16] == IO_BASE_HI);
    is_load_c = bus.dm_re_EX_DM & ~bus.dm_we_EX_DM;
    ram_idx_c = bus.addr_EX_DM[DM_AW-1:0];
  end

  // Stall: combinational while an I/O access waits in IDLE, forced in WAIT;
  // gated by rst so it falls together with io_req on an async reset
  always_comb begin
    stall_c = 1'b0;
    if (!rst) begin
      stall_c = ((state_q == ST_IDLE) && acc_c && io_sel_c) ||
                (state_q == ST_WAIT);
    end
    ram_we_c = bus.dm_we_EX_DM & ~io_sel_c & ~stall_c;
  end

  // Local RAM on the falling edge so load data settles before the next rising edge
  always_ff @(negedge clk) begin
    if (ram_we_c) begin
      mem[ram_idx_c] <= bus.wrt_data_EX_DM;
    end
    ram_rdata_q <= mem[ram_idx_c];
  end

  // I/O handshake FSM with timeout and sticky bus error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      io_req_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= 16'h0;
      io_wdata_q <= 32'h0;
      rdata_q    <= 32'h0;
      tmo_cnt_q  <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc_c && io_sel_c) begin
            io_we_q    <= bus.dm_we_EX_DM;
            io_addr_q  <= bus.addr_EX_DM[15:0];
            io_wdata_q <= bus.wrt_data_EX_DM;
            tmo_cnt_q  <= '0;
            io_req_q   <= 1'b1;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Ack takes priority over a coincident timeout
          if (bus.io_ack) begin
            if (!io_we_q) begin
              rdata_q <= bus.io_rdata;
            end
            io_req_q <= 1'b0;
            state_q  <= ST_DONE;
          end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
            rdata_q   <= ERR_DATA;
            bus_err_q <= 1'b1;
            io_req_q  <= 1'b0;
            state_q   <= ST_DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        ST_DONE: begin
          // Pipeline advances this cycle; the presented access is the one completing
          state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          io_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Load data select for the write-back mux
  always_comb begin
    rd_data_c = 32'h0;
    if (acc_c && !io_sel_c && is_load_c) begin
      rd_data_c = ram_rdata_q;
    end else if ((state_q == ST_DONE) && io_sel_c && is_load_c) begin
      rd_data_c = rdata_q;
    end
  end

  assign bus.dm_rd_data_EX_DM = rd_data_c;
  assign bus.stall_DM         = stall_c;
  assign bus.io_req           = io_req_q;
  assign bus.io_we            = io_we_q;
  assign bus.io_addr          = io_addr_q;
  assign bus.io_wdata         = io_wdata_q;
  assign bus.bus_err          = bus_err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: directed scenarios plus randomized
// local/I/O traffic against a transaction-level reference model.
module tb_dm_ctrl;

  localparam int unsigned DM_AW    = 12;
  localparam int unsigned TIMEOUT  = 64;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic clk;
  logic rst;

  dm_ctrl_if bus ();

  dm_ctrl #(
    .DM_AW      (DM_AW),
    .IO_BASE_HI (16'hC000),
    .TIMEOUT    (TIMEOUT),
    .ERR_DATA   (ERR_DATA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  logic [31:0] ref_mem [int];
  logic        bus_err_exp;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.dm_re_EX_DM    = re;
    bus.dm_we_EX_DM    = we;
    bus.addr_EX_DM     = a;
    bus.wrt_data_EX_DM = d;
  endtask

  // One local (or idle) cycle; model: RAM word addressed by low DM_AW bits
  task automatic local_op(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a[DM_AW-1:0]);
    drive(re, we, a, d);
    @(negedge clk); #1;
    check("loc_stall", 32'(bus.stall_DM), 32'h0);
    if (re && !we) begin
      if (ref_mem.exists(idx)) check("loc_rdata", bus.dm_rd_data_EX_DM, ref_mem[idx]);
    end else begin
      check("loc_rdata_zero", bus.dm_rd_data_EX_DM, 32'h0);
    end
    check("loc_bus_err", 32'(bus.bus_err), 32'(bus_err_exp));
    if (we) ref_mem[idx] = d;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Full I/O transaction; k = WAIT-cycle index at which ack is pulsed, -1 = never
  task automatic io_op(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input int k, input logic [31:0] r);
    int stall_cnt;
    int req_cyc;
    bit acked;
    logic [31:0] exp_rd;
    stall_cnt = 0;
    req_cyc   = 0;
    acked     = (k >= 0) && (k < int'(TIMEOUT));
    drive(re, we, a, d);
    @(negedge clk); #1;
    check("io_idle_req", 32'(bus.io_req), 32'h0);
    if (bus.stall_DM === 1'b1) stall_cnt++;
    @(posedge clk); #1;
    while (bus.io_req === 1'b1 && req_cyc < int'(TIMEOUT) + 8) begin
      if (req_cyc == k) begin
        bus.io_ack   = 1'b1;
        bus.io_rdata = r;
      end
      @(negedge clk); #1;
      check("io_addr", 32'(bus.io_addr), 32'(a[15:0]));
      check("io_we", 32'(bus.io_we), 32'(we));
      check("io_wdata", bus.io_wdata, d);
      if (bus.stall_DM === 1'b1) stall_cnt++;
      @(posedge clk); #1;
      bus.io_ack   = 1'b0;
      bus.io_rdata = $urandom;
      req_cyc++;
    end
    check("io_req_cycles", 32'(req_cyc), acked ? 32'(k + 1) : 32'(TIMEOUT));
    exp_rd = (re && !we) ? (acked ? r : ERR_DATA) : 32'h0;
    if (!acked) bus_err_exp = 1'b1;
    @(negedge clk); #1;
    check("io_done_stall", 32'(bus.stall_DM), 32'h0);
    check("io_stall_cycles", 32'(stall_cnt), acked ? 32'(k + 2) : 32'(TIMEOUT + 1));
    check("io_done_rdata", bus.dm_rd_data_EX_DM, exp_rd);
    check("io_bus_err", 32'(bus.bus_err), 32'(bus_err_exp));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [15:0] up;
    int kk;
    int mode;
    checks      = 0;
    failures    = 0;
    bus_err_exp = 1'b0;
    rst         = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    bus.io_ack   = 1'b0;
    bus.io_rdata = 32'h0;

    // Reset state
    #2;
    check("rst_io_req", 32'(bus.io_req), 32'h0);
    check("rst_stall", 32'(bus.stall_DM), 32'h0);
    check("rst_bus_err", 32'(bus.bus_err), 32'h0);
    check("rst_io_addr", 32'(bus.io_addr), 32'h0);
    check("rst_io_wdata", bus.io_wdata, 32'h0);
    check("rst_rdata", bus.dm_rd_data_EX_DM, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // 1: local store/load and address wrap
    local_op(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678);
    local_op(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    local_op(1'b1, 1'b0, 32'h0000_1010, 32'h0);
    local_op(1'b1, 1'b1, 32'h0000_0044, 32'h0BAD_F00D);

    // 2: I/O load, ack 3 cycles into the request
    io_op(1'b1, 1'b0, 32'hC000_0004, 32'h0, 3, 32'hCAFE_F00D);

    // 3: I/O store must not touch the aliased RAM word
    local_op(1'b0, 1'b1, 32'h0000_0020, 32'h55AA_55AA);
    io_op(1'b0, 1'b1, 32'hC000_0020, 32'h0000_00AA, 1, 32'h1111_1111);
    local_op(1'b1, 1'b0, 32'h0000_0020, 32'h0);

    // Ack outside WAIT is ignored
    bus.io_ack = 1'b1;
    @(negedge clk); #1;
    check("stray_ack_req", 32'(bus.io_req), 32'h0);
    check("stray_ack_stall", 32'(bus.stall_DM), 32'h0);
    @(posedge clk); #1;
    bus.io_ack = 1'b0;

    // 4: timeout, bus_err sticky across good accesses
    io_op(1'b1, 1'b0, 32'hC000_0100, 32'h0, -1, 32'h0);
    io_op(1'b1, 1'b0, 32'hC000_0104, 32'h0, 2, 32'h7777_0001);
    local_op(1'b1, 1'b0, 32'h0000_0010, 32'h0);

    // 5: async reset in the middle of WAIT
    drive(1'b1, 1'b0, 32'hC000_0008, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rstw_io_req", 32'(bus.io_req), 32'h0);
    check("rstw_stall", 32'(bus.stall_DM), 32'h0);
    check("rstw_bus_err", 32'(bus.bus_err), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    bus_err_exp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.io_ack   = 1'b1;
    bus.io_rdata = 32'hBADB_AD00;
    @(negedge clk); #1;
    check("rstw_ack_req", 32'(bus.io_req), 32'h0);
    check("rstw_ack_rdata", bus.dm_rd_data_EX_DM, 32'h0);
    @(posedge clk); #1;
    bus.io_ack = 1'b0;
    check("rstw_after_req", 32'(bus.io_req), 32'h0);
    check("rstw_after_stall", 32'(bus.stall_DM), 32'h0);

    // 6: back-to-back immediate acks, then ack on the final timeout cycle
    io_op(1'b1, 1'b0, 32'hC000_0030, 32'h0, 0, 32'hA5A5_0001);
    io_op(1'b1, 1'b0, 32'hC000_0034, 32'h0, 0, 32'h5A5A_0002);
    io_op(1'b1, 1'b0, 32'hC000_0038, 32'h0, int'(TIMEOUT) - 1, 32'h0123_4567);
    check("t6_bus_err", 32'(bus.bus_err), 32'h0);

    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 99) < 65) begin
        up = 16'($urandom);
        if (up == 16'hC000) up = 16'h0001;
        a = {up, 4'($urandom), 12'($urandom_range(0, 15) * 4)};
        mode = $urandom_range(0, 3);
        case (mode)
          0:       local_op(1'b1, 1'b0, a, 32'h0);
          1:       local_op(1'b0, 1'b1, a, $urandom);
          2:       local_op(1'b1, 1'b1, a, $urandom);
          default: local_op(1'b0, 1'b0, a, $urandom);
        endcase
      end else begin
        a  = {16'hC000, 16'($urandom)};
        kk = ($urandom_range(0, 14) == 0) ? -1 : int'($urandom_range(0, 6));
        mode = $urandom_range(0, 2);
        case (mode)
          0:       io_op(1'b1, 1'b0, a, $urandom, kk, $urandom);
          1:       io_op(1'b0, 1'b1, a, $urandom, kk, $urandom);
          default: io_op(1'b1, 1'b1, a, $urandom, kk, $urandom);
        endcase
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
Data-memory stage controller in the EX_DM pipeline slot. It sits directly upstream of the DM/WB write-back mux and produces dm_rd_data_EX_DM. Accesses to local addresses are served from an on-chip word-addressed RAM with no stall. Accesses to the memory-mapped I/O window run a req/ack handshake on the peripheral bus, stall the pipeline until completion, and time out with a bus error.

Parameters:
DM_AW, 12, local RAM word-address width (depth 2**DM_AW words of 32 bits)
IO_BASE_HI, 16'hC000, addr[31:16] value selecting the I/O window
TIMEOUT, 64, max WAIT cycles before abort
ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
dm_re_EX_DM  in  1  load in EX_DM stage
dm_we_EX_DM  in  1  store in EX_DM stage
addr_EX_DM  in  32  word address from ALU
wrt_data_EX_DM  in  32  store data
dm_rd_data_EX_DM  out  32  load data to write-back mux
stall_DM  out  1  freeze PC and all pipeline registers
io_req  out  1  peripheral request
io_we  out  1  peripheral write strobe (valid with io_req)
io_addr  out  16  addr[15:0], held during request
io_wdata  out  32  store data, held during request
io_rdata  in  32  peripheral read data (valid with io_ack)
io_ack  in  1  peripheral completion, 1-cycle pulse
bus_err  out  1  sticky timeout flag

Behaviour:
- Clock is clk. Reset is rst, asynchronous and active-high.
- Reset values: state=IDLE, io_req=0, io_we=0, io_addr=0, io_wdata=0, rdata_q=0, tmo_cnt=0, bus_err=0, stall_DM=0. RAM contents are not reset.
- Decode: io_sel = (addr_EX_DM[31:16]==IO_BASE_HI). acc = dm_re_EX_DM | dm_we_EX_DM.
- If dm_re and dm_we are both asserted, the access is treated as a store, and dm_rd_data_EX_DM=0.
- Local access (acc & !io_sel):
  - Index is addr[DM_AW-1:0]; upper bits are ignored and wrap.
  - Read and write occur on the falling edge of clk, so read data is valid before the next rising edge.
  - Zero latency and never stalls.
  - Stores take effect only when stall_DM=0.
- dm_rd_data_EX_DM:
  - RAM output for a local load.
  - rdata_q in DONE for an I/O load.
  - 32'h0 otherwise.
- FSM, all transitions on the rising edge:
  - IDLE:
    - stall_DM = acc & io_sel (combinational).
    - On an I/O access, capture io_we<=dm_we, io_addr<=addr[15:0], io_wdata<=wrt_data, tmo_cnt<=0, and go to WAIT.
  - WAIT:
    - io_req=1, stall_DM=1. Hold all io_* outputs stable.
    - If io_ack=1: rdata_q<=io_rdata (loads only; stores leave rdata_q unchanged), io_req<=0, go to DONE.
    - Else if tmo_cnt==TIMEOUT-1: rdata_q<=ERR_DATA, bus_err<=1, io_req<=0, go to DONE.
    - Else tmo_cnt++.
    - If io_ack and timeout coincide, ack wins and bus_err is not set.
  - DONE:
    - stall_DM=0, so the pipeline advances and write-back samples rdata_q. Go to IDLE.
    - An access presented while in DONE is the same, completing instruction and is not restarted.
- io_req is registered and deasserts the cycle after ack is sampled. io_ack outside WAIT is ignored.
- Back-to-back I/O accesses: each takes IDLE→WAIT→DONE, so there is always one IDLE cycle between requests.
- bus_err stays set until rst.
- rst during WAIT: io_req drops immediately (asynchronously), the FSM goes to IDLE, and no partial data is returned.
- Latency: an I/O access with ack arriving k cycles after entering WAIT (k≥0) holds stall_DM high for k+2 cycles. Data is valid on dm_rd_data_EX_DM in the DONE cycle.

Test Plan:
1. Local store 32'h12345678 to addr 0x00000010, then load from 0x00000010 → dm_rd_data_EX_DM=32'h12345678 in the load cycle, stall_DM never asserted; a load from 0x00001010 (DM_AW=12) wraps to the same word.
2. I/O load from 0xC0000004, bench acks 3 cycles after io_req rises with io_rdata=32'hCAFEF00D → io_addr=16'h0004, io_we=0, stall_DM high for exactly 5 cycles, DONE cycle shows 32'hCAFEF00D, io_req low the cycle after ack.
3. I/O store 32'h000000AA to 0xC0000020, ack after 1 cycle → io_we=1, io_wdata=32'hAA throughout the request, stall_DM high 3 cycles, dm_rd_data_EX_DM=0, RAM word 0x20 unchanged.
4. I/O load, no ack (TIMEOUT=64) → io_req high exactly 64 cycles, DONE returns 32'hDEADBEEF, bus_err=1 and stays 1 through subsequent good accesses until rst.
5. rst asserted mid-WAIT (cycle 2 of the request) → io_req and stall_DM drop without waiting for a clock edge, state=IDLE, bus_err=0; a later ack pulse is ignored.
6. Two consecutive I/O loads with immediate ack, plus ack coinciding with timeout on the final WAIT cycle → each returns its own io_rdata, one IDLE cycle between io_req pulses, bus_err remains 0.
